// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and its control decoder.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_SLTU  = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_XOR   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_NOR   = 4'd11;
  localparam logic [3:0] ALU_MULU  = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_RSV14 = 4'd14;
  localparam logic [3:0] ALU_RSV15 = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Multiply and divide are the only opcodes that leave IDLE.
  function automatic logic isIterOp(input logic [3:0] ctrl);
    return (ctrl == ALU_MULU) || (ctrl == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle over a
// shared 2*WIDTH shift register ({hi, lo}).
module alu_iter
  #(parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH))
  (input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;
  logic               r_div;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_next;

  // Mul: acc = {partial, multiplier}, add into the top half then shift right.
  // Div: acc = {remainder, dividend}, shift left and trial-subtract the divisor.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff     = w_shift - {1'b0, r_opnd};
    w_ge       = w_shift >= {1'b0, r_opnd};
    w_acc_next = r_acc;
    if (r_div) begin
      w_acc_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_ge};
    end else if (r_acc[0]) begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_div  <= 1'b0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_div  <= div_i;
      r_cnt  <= SHW'(WIDTH-1);
      r_opnd <= div_i ? b_i : a_i;
      r_acc  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - SHW'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  assign done_o = r_busy && (r_cnt == '0);
  assign lo_o   = r_acc[WIDTH-1:0];
  assign hi_o   = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU: single-cycle ops with a registered result, plus iterative
// mulu/divu sequenced by a small FSM; ready_o stalls the controller.
module alu_seq
  import alu_seq_pkg::*;
  #(parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH))
  (input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             zero_o,
   output logic             ovf_o);

  logic [1:0]       r_state;
  logic [3:0]       r_ctrl;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_src2;
  logic             r_pend;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_ovf;
  logic             r_valid;

  logic             w_accept;
  logic             w_iter_start;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_ovf;

  assign ready_o      = (r_state == ST_IDLE);
  assign w_accept     = start_i && ready_o;
  assign w_iter_start = w_accept && isIterOp(ctrl_i);

  always_comb begin
    w_sum       = r_src1 + r_src2;
    w_diff      = r_src1 - r_src2;
    w_shamt     = r_src2[SHW-1:0];
    w_sc_result = '0;
    w_sc_ovf    = 1'b0;
    case (r_ctrl)
      ALU_ADD: begin
        w_sc_result = w_sum;
        w_sc_ovf    = (r_src1[WIDTH-1] == r_src2[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_src1[WIDTH-1]);
      end
      ALU_SUB: begin
        w_sc_result = w_diff;
        w_sc_ovf    = (r_src1[WIDTH-1] != r_src2[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != r_src1[WIDTH-1]);
      end
      ALU_AND:   w_sc_result = r_src1 & r_src2;
      ALU_OR:    w_sc_result = r_src1 | r_src2;
      ALU_SLT:   w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(r_src1) < $signed(r_src2))};
      ALU_SLTU:  w_sc_result = {{(WIDTH-1){1'b0}}, (r_src1 < r_src2)};
      ALU_SLL:   w_sc_result = r_src1 << w_shamt;
      ALU_LUI:   w_sc_result = r_src2 << (WIDTH/2);
      ALU_XOR:   w_sc_result = r_src1 ^ r_src2;
      ALU_SRL:   w_sc_result = r_src1 >> w_shamt;
      ALU_SRA:   w_sc_result = $signed(r_src1) >>> w_shamt;
      ALU_NOR:   w_sc_result = ~(r_src1 | r_src2);
      ALU_RSV14: w_sc_result = '0;
      ALU_RSV15: w_sc_result = '0;
      default:   w_sc_result = '0;
    endcase
  end

  alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_iter_start),
    .div_i   (ctrl_i == ALU_DIVU),
    .a_i     (src1_i),
    .b_i     (src2_i),
    .done_o  (w_iter_done),
    .lo_o    (w_iter_lo),
    .hi_o    (w_iter_hi));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_iter_start) r_state <= (ctrl_i == ALU_DIVU) ? ST_DIV : ST_MUL;
        ST_MUL,
        ST_DIV:  if (w_iter_done) r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // r_pend marks a single-cycle op whose result is registered on the next edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_accept && !isIterOp(ctrl_i);
      if (w_accept) begin
        r_ctrl <= ctrl_i;
        r_src1 <= src1_i;
        r_src2 <= src2_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_ovf       <= 1'b0;
      r_valid     <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_result    <= w_iter_lo;
      r_result_hi <= w_iter_hi;
      r_ovf       <= 1'b0;
      r_valid     <= 1'b1;
    end else if (r_pend) begin
      r_result    <= w_sc_result;
      r_result_hi <= '0;
      r_ovf       <= w_sc_ovf;
      r_valid     <= 1'b1;
    end else begin
      r_valid     <= 1'b0;
    end
  end

  assign valid_o     = r_valid;
  assign result_o    = r_result;
  assign result_hi_o = r_result_hi;
  assign zero_o      = (r_result == '0);
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (WIDTH=32) against an arithmetic
// reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   ctrl_i = '0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic [W-1:0] result_hi_o;
  logic         zero_o;
  logic         ovf_o;

  int checkCount = 0;
  int errorCount = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .ctrl_i      (ctrl_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .result_hi_o (result_hi_o),
    .zero_o      (zero_o),
    .ovf_o       (ovf_o));

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on 64-bit values.
  function automatic void refModel(input logic [3:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res,
                                   output logic [W-1:0] hi, output logic ovf);
    longint      sa;
    longint      sb;
    longint      s;
    logic [63:0] prod;
    int          sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b[4:0]);
    res = '0;
    hi  = '0;
    ovf = 1'b0;
    case (c)
      4'd0:  begin s = sa + sb; res = s[31:0]; ovf = (s != longint'($signed(res))); end
      4'd1:  begin s = sa - sb; res = s[31:0]; ovf = (s != longint'($signed(res))); end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  res = (a < b) ? 32'd1 : 32'd0;
      4'd6:  res = a << sh;
      4'd7:  res = b << 16;
      4'd8:  res = a ^ b;
      4'd9:  res = a >> sh;
      4'd10: begin s = sa >>> sh; res = s[31:0]; end
      4'd11: res = ~(a | b);
      4'd12: begin prod = {32'd0, a} * {32'd0, b}; res = prod[31:0]; hi = prod[63:32]; end
      4'd13: begin
        if (b == 0) begin res = '1; hi = a; end
        else begin res = a / b; hi = a % b; end
      end
      default: res = '0;
    endcase
  endfunction

  // Issue one op, wait for valid_o (bounded), compare with the model.
  // pokeAt >= 0 asserts a stray add start at that wait cycle, which must be ignored.
  task automatic applyStimulus(input logic [3:0] c, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int pokeAt);
    logic [W-1:0] eRes;
    logic [W-1:0] eHi;
    logic         eOvf;
    int           eLat;
    int           lat;
    bit           readyBad;
    refModel(c, a, b, eRes, eHi, eOvf);
    eLat = (c == 4'd12 || c == 4'd13) ? W + 1 : 1;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
    @(negedge clk_i);
    start_i  = 1'b0;
    lat      = 0;
    readyBad = 1'b0;
    while (!valid_o && lat < 100) begin
      if (ready_o) readyBad = 1'b1;
      if (lat == pokeAt) begin
        start_i = 1'b1; ctrl_i = 4'd0; src1_i = 32'd1; src2_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    checkOutput($sformatf("lat op%0d", c), 64'(lat), 64'(eLat));
    checkOutput($sformatf("res op%0d a=%0h b=%0h", c, a, b), 64'(result_o), 64'(eRes));
    checkOutput($sformatf("hi op%0d a=%0h b=%0h", c, a, b), 64'(result_hi_o), 64'(eHi));
    checkOutput($sformatf("zero op%0d", c), 64'(zero_o), 64'(eRes == 0));
    checkOutput($sformatf("ovf op%0d a=%0h b=%0h", c, a, b), 64'(ovf_o), 64'(eOvf));
    if (eLat > 1) checkOutput($sformatf("readyLow op%0d", c), 64'(readyBad), 64'(0));
    if (pokeAt >= 0) begin
      @(negedge clk_i);
      checkOutput("noExtraValid", 64'(valid_o), 64'(0));
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit sawValid;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Load a nonzero result, then reset asynchronously between edges.
    applyStimulus(4'd0, 32'd5, 32'd6, -1);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("rst result", 64'(result_o), 64'(0));
    checkOutput("rst hi", 64'(result_hi_o), 64'(0));
    checkOutput("rst zero", 64'(zero_o), 64'(1));
    checkOutput("rst ready", 64'(ready_o), 64'(1));
    checkOutput("rst valid", 64'(valid_o), 64'(0));
    checkOutput("rst ovf", 64'(ovf_o), 64'(0));
    #1 rst_i = 1'b1;

    // Back-to-back add overflow then sub.
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'd0; src1_i = 32'h7FFF_FFFF; src2_i = 32'd1;
    @(negedge clk_i);
    checkOutput("b2b valid0", 64'(valid_o), 64'(0));
    ctrl_i = 4'd1; src1_i = 32'd5; src2_i = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("b2b add valid", 64'(valid_o), 64'(1));
    checkOutput("b2b add res", 64'(result_o), 64'h8000_0000);
    checkOutput("b2b add ovf", 64'(ovf_o), 64'(1));
    @(negedge clk_i);
    checkOutput("b2b sub valid", 64'(valid_o), 64'(1));
    checkOutput("b2b sub res", 64'(result_o), 64'(0));
    checkOutput("b2b sub zero", 64'(zero_o), 64'(1));
    checkOutput("b2b sub ovf", 64'(ovf_o), 64'(0));
    @(negedge clk_i);
    checkOutput("b2b valid end", 64'(valid_o), 64'(0));

    applyStimulus(4'd4, 32'hFFFF_FFFF, 32'd1, -1);
    applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd1, -1);
    applyStimulus(4'd10, 32'h8000_0000, 32'h21, -1);
    applyStimulus(4'd7, 32'd0, 32'h1234, -1);
    applyStimulus(4'd6, 32'hDEAD_BEEF, 32'd0, -1);
    applyStimulus(4'd12, 32'hFFFF_FFFF, 32'd2, 5);
    applyStimulus(4'd13, 32'd100, 32'd7, -1);
    applyStimulus(4'd13, 32'd9, 32'd0, -1);

    // Abandon a divide partway through.
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'd13; src1_i = 32'd1000; src2_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("abort ready", 64'(ready_o), 64'(1));
    checkOutput("abort valid", 64'(valid_o), 64'(0));
    checkOutput("abort result", 64'(result_o), 64'(0));
    #1 rst_i = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("abort noValid", 64'(sawValid), 64'(0));
    applyStimulus(4'd0, 32'd3, 32'd4, -1);

    for (int i = 0; i < 200; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
